// File: rtl/voice_mixer.sv
// Three-voice sample mixer: gathers one sample per sounding voice for each codec
// request, then sums, shifts and saturates them into a single mixed sample.
module voice_mixer #(
    parameter int SAMPLE_W = 18,
    parameter int SHIFT    = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play_enable,
    input  logic                generate_next_sample,
    input  logic [2:0]          voice_active,
    input  logic [2:0]          sample_ready,
    input  logic [SAMPLE_W-1:0] sample_in1,
    input  logic [SAMPLE_W-1:0] sample_in2,
    input  logic [SAMPLE_W-1:0] sample_in3,
    output logic [SAMPLE_W-1:0] mixed_sample,
    output logic                mixed_ready,
    output logic                overflow,
    output logic                timeout_err,
    output logic                overrun
);

    localparam int SW = SAMPLE_W + 2;
    localparam logic signed [SW-1:0] MAXV = $signed({3'b000, {(SAMPLE_W-1){1'b1}}});
    localparam logic signed [SW-1:0] MINV = $signed({3'b111, {(SAMPLE_W-1){1'b0}}});

    typedef enum logic [1:0] {IDLE, COLLECT, SUM, OUT} state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] cap1, cap2, cap3;
    logic [2:0]          got;
    logic [7:0]          timer;

    logic [2:0]          take;
    logic [2:0]          got_next;
    logic signed [SW-1:0] sum, scaled;
    logic [SAMPLE_W-1:0] sat;
    logic                clamp;

    always_comb begin
        take     = sample_ready & ~got;
        got_next = got | sample_ready;
        sum      = $signed({{2{cap1[SAMPLE_W-1]}}, cap1})
                 + $signed({{2{cap2[SAMPLE_W-1]}}, cap2})
                 + $signed({{2{cap3[SAMPLE_W-1]}}, cap3});
        scaled   = sum >>> SHIFT;
        clamp    = 1'b0;
        sat      = scaled[SAMPLE_W-1:0];
        if (scaled > MAXV) begin
            sat   = MAXV[SAMPLE_W-1:0];
            clamp = 1'b1;
        end else if (scaled < MINV) begin
            sat   = MINV[SAMPLE_W-1:0];
            clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cap1         <= '0;
            cap2         <= '0;
            cap3         <= '0;
            got          <= '0;
            timer        <= '0;
            mixed_sample <= '0;
            mixed_ready  <= 1'b0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            mixed_ready <= 1'b0;
            if (generate_next_sample && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (generate_next_sample && play_enable) begin
                        cap1  <= '0;
                        cap2  <= '0;
                        cap3  <= '0;
                        got   <= ~voice_active;
                        timer <= '0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!play_enable) begin
                        state <= IDLE;
                    end else begin
                        if (take[0]) cap1 <= sample_in1;
                        if (take[1]) cap2 <= sample_in2;
                        if (take[2]) cap3 <= sample_in3;
                        got <= got_next;
                        // Completion this cycle wins over an expiring timer.
                        if (&got_next) begin
                            state <= SUM;
                        end else if (timer == 8'(TIMEOUT - 1)) begin
                            state       <= SUM;
                            timeout_err <= 1'b1;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                SUM: begin
                    if (!play_enable) begin
                        state <= IDLE;
                    end else begin
                        mixed_sample <= sat;
                        mixed_ready  <= 1'b1;
                        if (clamp) overflow <= 1'b1;
                        state <= OUT;
                    end
                end
                OUT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: two instances (SHIFT=0 and SHIFT=1, TIMEOUT=8) share stimulus;
// expected pulses are queued by a reference model and popped by a monitor.
module tb_voice_mixer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset, play_enable, gen;
    logic [2:0]  va, sr;
    logic [17:0] sd [3];
    logic [17:0] ms0, ms1;
    logic        mr0, mr1, ovf0, ovf1, to0, to1, or0, or1;

    voice_mixer #(.SAMPLE_W(18), .SHIFT(0), .TIMEOUT(TO)) u_s0 (
        .clk(clk), .reset(reset), .play_enable(play_enable), .generate_next_sample(gen),
        .voice_active(va), .sample_ready(sr),
        .sample_in1(sd[0]), .sample_in2(sd[1]), .sample_in3(sd[2]),
        .mixed_sample(ms0), .mixed_ready(mr0), .overflow(ovf0),
        .timeout_err(to0), .overrun(or0));

    voice_mixer #(.SAMPLE_W(18), .SHIFT(1), .TIMEOUT(TO)) u_s1 (
        .clk(clk), .reset(reset), .play_enable(play_enable), .generate_next_sample(gen),
        .voice_active(va), .sample_ready(sr),
        .sample_in1(sd[0]), .sample_in2(sd[1]), .sample_in3(sd[2]),
        .mixed_sample(ms1), .mixed_ready(mr1), .overflow(ovf1),
        .timeout_err(to1), .overrun(or1));

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] v0;
        logic [17:0] v1;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // transaction description: per-voice sample/pulse time, optional repeat pulse
    int   tv_s [3];
    int   tv_p1[3];
    int   tv_s2[3];
    int   tv_p2[3];

    // model state
    bit          m_ovf0, m_ovf1, m_to, m_or;
    logic [17:0] m_last0, m_last1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mr0 || mr1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: ready0=%0b ready1=%0b at cycle %0d, expected none",
                         mr0, mr1, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ready_cycle", cyc, e.cyc);
                chk("both_ready", int'({mr0, mr1}), 3);
                chk("mixed_sample_shift0", int'(ms0), int'(e.v0));
                chk("mixed_sample_shift1", int'(ms1), int'(e.v1));
            end
        end
    end

    // Behavioural model of one mix: end_c = last COLLECT cycle relative to request.
    function automatic void model(input logic [2:0] act, input int sh, output int end_c,
                                  output bit to_f, output logic [17:0] v, output bit cl);
        int f[3];
        int val[3];
        bit all_in;
        int last;
        int sum;
        int sc;
        all_in = 1'b1;
        last   = 1;
        for (int i = 0; i < 3; i++) begin
            f[i] = -1;
            val[i] = 0;
            if (tv_p1[i] >= 1) begin
                f[i] = tv_p1[i];
                val[i] = tv_s[i];
            end else if (tv_p2[i] >= 1) begin
                f[i] = tv_p2[i];
                val[i] = tv_s2[i];
            end
            if (act[i]) begin
                if (f[i] < 1 || f[i] > TO) all_in = 1'b0;
                else if (f[i] > last) last = f[i];
            end
        end
        end_c = all_in ? last : TO;
        to_f  = !all_in;
        sum = 0;
        for (int i = 0; i < 3; i++)
            if (act[i] && f[i] >= 1 && f[i] <= end_c) sum += val[i];
        sc = sum >>> sh;
        cl = 1'b0;
        if (sc > 131071) begin sc = 131071; cl = 1'b1; end
        if (sc < -131072) begin sc = -131072; cl = 1'b1; end
        v = sc[17:0];
    endfunction

    task automatic check_zero_outputs();
        chk("rst_mixed_sample0", int'(ms0), 0);
        chk("rst_mixed_sample1", int'(ms1), 0);
        chk("rst_ready", int'({mr0, mr1}), 0);
        chk("rst_flags", int'({ovf0, ovf1, to0, to1, or0, or1}), 0);
    endtask

    // abort_at=0 means play_enable low during the request itself (request blocked).
    task automatic run_mix(input logic [2:0] act, input int gen_at, input int abort_at,
                           input int rst_at);
        int e0, e1;
        bit t0, t1, c0, c1;
        logic [17:0] v0, v1;
        int x;
        model(act, 0, e0, t0, v0, c0);
        model(act, 1, e1, t1, v1, c1);
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            reset       = (k != rst_at);
            gen         = (k == 0) || (k == gen_at);
            play_enable = (k != abort_at);
            va          = (k == 0) ? act : 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                sr[i] = (tv_p1[i] == k) || (tv_p2[i] == k);
                if (tv_p1[i] == k) x = tv_s[i];
                else if (tv_p2[i] == k) x = tv_s2[i];
                else x = int'($urandom);
                sd[i] = x[17:0];
            end
            if (k == 0 && abort_at != 0) begin
                if (abort_at >= 1 && abort_at <= e0 + 1) begin
                    if (t0 && abort_at == e0 + 1) m_to = 1'b1;
                end else if (rst_at < 0) begin
                    exp_q.push_back('{v0: v0, v1: v1, cyc: cyc + e0 + 2});
                    m_ovf0 |= c0;
                    m_ovf1 |= c1;
                    m_to   |= t0;
                    m_last0 = v0;
                    m_last1 = v1;
                    if (gen_at >= 1 && gen_at <= e0 + 2) m_or = 1'b1;
                end
            end
            if (k == rst_at) begin
                #1;
                exp_q.delete();
                m_ovf0 = 0; m_ovf1 = 0; m_to = 0; m_or = 0;
                m_last0 = '0; m_last1 = '0;
                check_zero_outputs();
            end
        end
        @(posedge clk);
        #1;
        gen = 1'b0; sr = '0; play_enable = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("pending_pulses", exp_q.size(), 0);
        chk("overflow_shift0", int'(ovf0), int'(m_ovf0));
        chk("overflow_shift1", int'(ovf1), int'(m_ovf1));
        chk("timeout_err", int'({to0, to1}), m_to ? 3 : 0);
        chk("overrun", int'({or0, or1}), m_or ? 3 : 0);
        chk("held_sample0", int'(ms0), int'(m_last0));
        chk("held_sample1", int'(ms1), int'(m_last1));
        exp_q.delete();
    endtask

    task automatic set_voice(input int i, input int s, input int p1, input int s2, input int p2);
        tv_s[i] = s; tv_p1[i] = p1; tv_s2[i] = s2; tv_p2[i] = p2;
    endtask

    initial begin
        reset = 1'b0; play_enable = 1'b1; gen = 1'b0; va = '0; sr = '0;
        sd[0] = '0; sd[1] = '0; sd[2] = '0;
        m_ovf0 = 0; m_ovf1 = 0; m_to = 0; m_or = 0; m_last0 = '0; m_last1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs();
        reset = 1'b1;
        @(posedge clk);

        // basic three-voice mix
        set_voice(0, 1000, 2, 0, -1); set_voice(1, 2000, 3, 0, -1); set_voice(2, 3000, 4, 0, -1);
        run_mix(3'b111, -1, -1, -1);
        // single voice; pulses on inactive voices ignored
        set_voice(0, 7777, 2, 0, -1); set_voice(1, -5000, 2, 0, -1); set_voice(2, 999, 3, 0, -1);
        run_mix(3'b010, -1, -1, -1);
        // no voices sounding
        set_voice(0, 5, 1, 0, -1); set_voice(1, 5, 1, 0, -1); set_voice(2, 5, 1, 0, -1);
        run_mix(3'b000, -1, -1, -1);
        // positive and negative saturation
        set_voice(0, 131071, 1, 0, -1); set_voice(1, 131071, 1, 0, -1); set_voice(2, 131071, 1, 0, -1);
        run_mix(3'b111, -1, -1, -1);
        set_voice(0, -131072, 1, 0, -1); set_voice(1, -131072, 2, 0, -1); set_voice(2, -131072, 1, 0, -1);
        run_mix(3'b111, -1, -1, -1);
        // missing voice times out
        set_voice(0, 11, 3, 0, -1); set_voice(1, 22, 3, 0, -1); set_voice(2, 333, -1, 0, -1);
        run_mix(3'b100, -1, -1, -1);
        // request during COLLECT and in the OUT cycle
        set_voice(0, 10, 3, 0, -1); set_voice(1, 20, 4, 0, -1); set_voice(2, 30, 5, 0, -1);
        run_mix(3'b111, 2, -1, -1);
        run_mix(3'b111, 7, -1, -1);
        // abort mid-COLLECT, abort in SUM, blocked request
        set_voice(0, 40, 2, 0, -1); set_voice(1, 50, 6, 0, -1); set_voice(2, 60, -1, 0, -1);
        run_mix(3'b011, -1, 4, -1);
        run_mix(3'b011, -1, 7, -1);
        run_mix(3'b011, -1, 0, -1);
        // repeat pulse ignored; pulse in request cycle ignored
        set_voice(0, 100, 2, 900, 3); set_voice(1, 300, 0, -400, 4); set_voice(2, 0, -1, 0, -1);
        run_mix(3'b011, -1, -1, -1);
        // reset during SUM
        set_voice(0, 1, 1, 0, -1); set_voice(1, 2, 2, 0, -1); set_voice(2, 3, 3, 0, -1);
        run_mix(3'b111, -1, -1, 4);

        for (int t = 0; t < 60; t++) begin
            logic [2:0] act;
            int e, g, a;
            bit tf, cf;
            logic [17:0] vv;
            act = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                int p1, p2;
                p1 = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, 11));
                p2 = (p1 >= 0 && $urandom_range(0, 2) == 0) ? p1 + int'($urandom_range(1, 3)) : -1;
                set_voice(i, int'($urandom_range(0, 262143)) - 131072, p1,
                          int'($urandom_range(0, 262143)) - 131072, p2);
            end
            model(act, 1, e, tf, vv, cf);
            g = -1;
            a = -1;
            case ($urandom_range(0, 9))
                0, 1: g = int'($urandom_range(1, e + 2));
                2:    a = int'($urandom_range(1, e + 1));
                3:    a = 0;
                default: ;
            endcase
            run_mix(act, g, a, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
